// File: rtl/i2c_txn_arbiter.sv
// Shares one byte-level I2C master between two requesters at transaction granularity.
// A granted requester keeps the bus from START to STOP; a stalled transaction is closed with a forced STOP.
module i2c_txn_arbiter #(
    parameter int TIMEOUT_CYC = 27000000,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    output logic [1:0]       gnt,
    input  logic [1:0]       cmd_valid,
    input  logic [3:0]       cmd_code,
    input  logic [15:0]      cmd_data,
    output logic [1:0]       cmd_ready,
    output logic [1:0]       rsp_valid,
    output logic [7:0]       rsp_data,
    output logic             rsp_nack,
    output logic             m_cmd_valid,
    output logic [1:0]       m_cmd_code,
    output logic [7:0]       m_cmd_data,
    input  logic             m_cmd_ready,
    input  logic             m_rsp_valid,
    input  logic [7:0]       m_rsp_data,
    input  logic             m_rsp_nack,
    output logic             busy,
    output logic [CNT_W-1:0] timeout_cnt
);

    localparam int IW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);
    localparam logic [1:0] C_START = 2'b00;
    localparam logic [1:0] C_STOP  = 2'b11;

    typedef enum logic [2:0] {IDLE, GRANT, OPEN, WAIT_RSP, ABORT, ABORT_WAIT} state_t;

    state_t            state, state_nx;
    logic [1:0]        gnt_nx;
    logic              last, last_nx;
    logic              ret_open, ret_open_nx;
    logic              perr, perr_nx;
    logic [IW-1:0]     idle_cnt, idle_cnt_nx;
    logic [CNT_W-1:0]  timeout_cnt_nx;
    logic              g_valid;
    logic [1:0]        g_code;
    logic [7:0]        g_data;

    // Granted requester's command; all zero when nobody owns the bus.
    always_comb begin
        g_valid = |(cmd_valid & gnt);
        g_code  = 2'b00;
        g_data  = 8'h00;
        if (gnt[1]) begin
            g_code = cmd_code[3:2];
            g_data = cmd_data[15:8];
        end else if (gnt[0]) begin
            g_code = cmd_code[1:0];
            g_data = cmd_data[7:0];
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            gnt         <= 2'b00;
            last        <= 1'b1;
            ret_open    <= 1'b0;
            perr        <= 1'b0;
            idle_cnt    <= '0;
            timeout_cnt <= '0;
        end else begin
            state       <= state_nx;
            gnt         <= gnt_nx;
            last        <= last_nx;
            ret_open    <= ret_open_nx;
            perr        <= perr_nx;
            idle_cnt    <= idle_cnt_nx;
            timeout_cnt <= timeout_cnt_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        gnt_nx         = gnt;
        last_nx        = last;
        ret_open_nx    = ret_open;
        perr_nx        = 1'b0;
        idle_cnt_nx    = idle_cnt;
        timeout_cnt_nx = timeout_cnt;
        cmd_ready      = 2'b00;
        rsp_valid      = 2'b00;
        rsp_data       = 8'h00;
        rsp_nack       = 1'b0;
        m_cmd_valid    = 1'b0;
        m_cmd_code     = 2'b00;
        m_cmd_data     = 8'h00;

        // Error response for a non-START command swallowed in GRANT one cycle earlier.
        if (perr) begin
            rsp_valid = gnt;
            rsp_nack  = 1'b1;
        end

        case (state)
            IDLE: begin
                if (req == 2'b01)      gnt_nx = 2'b01;
                else if (req == 2'b10) gnt_nx = 2'b10;
                else if (req == 2'b11) gnt_nx = last ? 2'b01 : 2'b10;
                if (|req) state_nx = GRANT;
            end
            GRANT: begin
                cmd_ready   = gnt & {2{m_cmd_ready}};
                m_cmd_code  = g_code;
                m_cmd_data  = g_data;
                m_cmd_valid = g_valid && (g_code == C_START);
                if (g_valid && m_cmd_ready) begin
                    if (g_code == C_START) begin
                        ret_open_nx = 1'b1;
                        state_nx    = WAIT_RSP;
                    end else begin
                        perr_nx = 1'b1;
                    end
                end else if ((req & gnt) == 2'b00) begin
                    state_nx = IDLE;
                    gnt_nx   = 2'b00;
                    last_nx  = gnt[1];
                end
            end
            OPEN: begin
                cmd_ready   = gnt & {2{m_cmd_ready}};
                m_cmd_code  = g_code;
                m_cmd_data  = g_data;
                m_cmd_valid = g_valid;
                if (g_valid && m_cmd_ready) begin
                    idle_cnt_nx = '0;
                    ret_open_nx = (g_code != C_STOP);
                    state_nx    = WAIT_RSP;
                end else if (!g_valid) begin
                    if (idle_cnt == IDLE_LAST) begin
                        idle_cnt_nx = '0;
                        state_nx    = ABORT;
                    end else begin
                        idle_cnt_nx = idle_cnt + 1'b1;
                    end
                end
            end
            WAIT_RSP: begin
                if (m_rsp_valid) begin
                    rsp_valid = gnt;
                    rsp_data  = m_rsp_data;
                    rsp_nack  = m_rsp_nack;
                    state_nx  = ret_open ? OPEN : GRANT;
                end
            end
            ABORT: begin
                m_cmd_valid = 1'b1;
                m_cmd_code  = C_STOP;
                if (m_cmd_ready) state_nx = ABORT_WAIT;
            end
            ABORT_WAIT: begin
                // The forced STOP's completion belongs to the arbiter, not the requester.
                if (m_rsp_valid) begin
                    state_nx = IDLE;
                    gnt_nx   = 2'b00;
                    last_nx  = gnt[1];
                    if (timeout_cnt != {CNT_W{1'b1}}) timeout_cnt_nx = timeout_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed self-checking bench for i2c_txn_arbiter with a short timeout.
// The bench plays both requesters and the byte-level master by hand.
module tb_i2c_txn_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [1:0]  cmd_valid;
    logic [3:0]  cmd_code;
    logic [15:0] cmd_data;
    logic [1:0]  cmd_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_nack;
    logic        m_cmd_valid;
    logic [1:0]  m_cmd_code;
    logic [7:0]  m_cmd_data;
    logic        m_cmd_ready;
    logic        m_rsp_valid;
    logic [7:0]  m_rsp_data;
    logic        m_rsp_nack;
    logic        busy;
    logic [7:0]  timeout_cnt;

    int checks = 0;
    int errors = 0;
    int rsp0_cnt = 0;
    logic [9:0] mon_q[$];

    i2c_txn_arbiter #(.TIMEOUT_CYC(16), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_nack(rsp_nack), .m_cmd_valid(m_cmd_valid), .m_cmd_code(m_cmd_code),
        .m_cmd_data(m_cmd_data), .m_cmd_ready(m_cmd_ready), .m_rsp_valid(m_rsp_valid),
        .m_rsp_data(m_rsp_data), .m_rsp_nack(m_rsp_nack), .busy(busy),
        .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    // Record every command the master accepts and every response seen by requester 0.
    always @(negedge clk) begin
        if (m_cmd_valid && m_cmd_ready) mon_q.push_back({m_cmd_code, m_cmd_data});
        if (rsp_valid[0]) rsp0_cnt++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted command followed by its master completion.
    task automatic do_cmd(input int r, input logic [1:0] code, input logic [7:0] data,
                          input logic [7:0] rd, input logic nack);
        cmd_valid[r] = 1'b1;
        cmd_code[r*2 +: 2] = code;
        cmd_data[r*8 +: 8] = data;
        m_cmd_ready = 1'b1;
        tick();
        cmd_valid[r] = 1'b0;
        m_cmd_ready = 1'b0;
        m_rsp_valid = 1'b1;
        m_rsp_data = rd;
        m_rsp_nack = nack;
        tick();
        m_rsp_valid = 1'b0;
        m_rsp_data = 8'h00;
        m_rsp_nack = 1'b0;
    endtask

    task automatic do_abort_cycle();
        req = 2'b01;
        tick();
        do_cmd(0, 2'b00, 8'h90, 8'h00, 1'b0);
        repeat (16) tick();
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        m_rsp_valid = 1'b1;
        tick();
        m_rsp_valid = 1'b0;
        req = 2'b00;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 2'b11;
        cmd_valid = 2'b11;
        cmd_data = 16'hFFFF;
        m_rsp_valid = 1'b1;
        m_rsp_data = 8'hA5;
        tick();
        tick();
        checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL reset_gnt got %b exp 00", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
        checks++; if (timeout_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_tcnt got %0d exp 0", timeout_cnt); end
        checks++; if ({cmd_ready, rsp_valid, rsp_data, rsp_nack} !== 13'd0) begin errors++; $display("[TB] FAIL reset_rsp got %h exp 0", {cmd_ready, rsp_valid, rsp_data, rsp_nack}); end
        checks++; if ({m_cmd_valid, m_cmd_code, m_cmd_data} !== 11'd0) begin errors++; $display("[TB] FAIL reset_mcmd got %h exp 0", {m_cmd_valid, m_cmd_code, m_cmd_data}); end
        req = 2'b00;
        cmd_valid = 2'b00;
        cmd_data = 16'h0000;
        m_rsp_valid = 1'b0;
        m_rsp_data = 8'h00;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        req = 2'b11;
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL rr_pre_gnt got %b exp 00", gnt); end
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL rr_tie_gnt got %b exp 01", gnt); end
        do_cmd(0, 2'b00, 8'h20, 8'h00, 1'b0);
        do_cmd(0, 2'b01, 8'h55, 8'h00, 1'b0);
        do_cmd(0, 2'b11, 8'h00, 8'h00, 1'b0);
        req = 2'b10;
        tick();
        checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL rr_gap_gnt got %b exp 00", gnt); end
        tick();
        checks++; if (gnt !== 2'b10) begin errors++; $display("[TB] FAIL rr_next_gnt got %b exp 10", gnt); end
        req = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_full_write();
        logic [9:0] exp_cmd[4];
        int base_q;
        int base_r;
        exp_cmd[0] = {2'b00, 8'hB8};
        exp_cmd[1] = {2'b01, 8'h03};
        exp_cmd[2] = {2'b01, 8'h0D};
        exp_cmd[3] = {2'b11, 8'h00};
        base_q = mon_q.size();
        base_r = rsp0_cnt;
        req = 2'b01;
        tick();
        do_cmd(0, 2'b00, 8'hB8, 8'h00, 1'b0);
        do_cmd(0, 2'b01, 8'h03, 8'h00, 1'b0);
        do_cmd(0, 2'b01, 8'h0D, 8'h00, 1'b0);
        do_cmd(0, 2'b11, 8'h00, 8'h00, 1'b0);
        checks++; if (mon_q.size() - base_q !== 4) begin errors++; $display("[TB] FAIL fw_cmd_count got %0d exp 4", mon_q.size() - base_q); end
        for (int i = 0; i < 4; i++) begin
            if (base_q + i < mon_q.size()) begin
                checks++; if (mon_q[base_q + i] !== exp_cmd[i]) begin errors++; $display("[TB] FAIL fw_cmd%0d got %h exp %h", i, mon_q[base_q + i], exp_cmd[i]); end
            end
        end
        checks++; if (rsp0_cnt - base_r !== 4) begin errors++; $display("[TB] FAIL fw_rsp_count got %0d exp 4", rsp0_cnt - base_r); end
        req = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_isolation();
        req = 2'b10;
        tick();
        do_cmd(1, 2'b00, 8'hA1, 8'h00, 1'b0);
        req = 2'b11;
        cmd_valid[0] = 1'b1;
        cmd_code[1:0] = 2'b00;
        cmd_data[7:0] = 8'h5A;
        cmd_data[15:8] = 8'h00;
        m_cmd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (cmd_ready !== 2'b10) begin errors++; $display("[TB] FAIL iso_ready got %b exp 10", cmd_ready); end
            checks++; if (m_cmd_valid !== 1'b0 || m_cmd_data === 8'h5A) begin errors++; $display("[TB] FAIL iso_mcmd got %b/%h exp 0/not 5a", m_cmd_valid, m_cmd_data); end
            tick();
        end
        cmd_valid[0] = 1'b0;
        m_cmd_ready = 1'b0;
        req = 2'b10;
        cmd_valid[1] = 1'b1;
        cmd_code[3:2] = 2'b10;
        cmd_data[15:8] = 8'h01;
        m_cmd_ready = 1'b1;
        tick();
        cmd_valid[1] = 1'b0;
        m_cmd_ready = 1'b0;
        m_rsp_valid = 1'b1;
        m_rsp_data = 8'hC3;
        m_rsp_nack = 1'b1;
        #1;
        checks++; if ({rsp_valid, rsp_data, rsp_nack} !== {2'b10, 8'hC3, 1'b1}) begin errors++; $display("[TB] FAIL iso_read_rsp got %b/%h/%b exp 10/c3/1", rsp_valid, rsp_data, rsp_nack); end
        tick();
        m_rsp_valid = 1'b0;
        m_rsp_data = 8'h00;
        m_rsp_nack = 1'b0;
        do_cmd(1, 2'b11, 8'h00, 8'h00, 1'b0);
        checks++; if (gnt !== 2'b10 || busy !== 1'b1) begin errors++; $display("[TB] FAIL iso_after_stop got %b/%b exp 10/1", gnt, busy); end
        req = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_protocol_error();
        req = 2'b01;
        tick();
        cmd_valid[0] = 1'b1;
        cmd_code[1:0] = 2'b01;
        cmd_data[7:0] = 8'h77;
        m_cmd_ready = 1'b1;
        #1;
        checks++; if (cmd_ready !== 2'b01 || m_cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL perr_consume got %b/%b exp 01/0", cmd_ready, m_cmd_valid); end
        tick();
        cmd_valid[0] = 1'b0;
        m_cmd_ready = 1'b0;
        #1;
        checks++; if (rsp_valid !== 2'b01 || rsp_nack !== 1'b1) begin errors++; $display("[TB] FAIL perr_rsp got %b/%b exp 01/1", rsp_valid, rsp_nack); end
        tick();
        checks++; if (rsp_valid !== 2'b00 || gnt !== 2'b01) begin errors++; $display("[TB] FAIL perr_after got %b/%b exp 00/01", rsp_valid, gnt); end
        req = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        req = 2'b01;
        tick();
        do_cmd(0, 2'b00, 8'h90, 8'h00, 1'b0);
        repeat (15) tick();
        checks++; if (m_cmd_valid !== 1'b0 || gnt !== 2'b01) begin errors++; $display("[TB] FAIL to_early got %b/%b exp 0/01", m_cmd_valid, gnt); end
        tick();
        checks++; if ({m_cmd_valid, m_cmd_code, m_cmd_data} !== {1'b1, 2'b11, 8'h00}) begin errors++; $display("[TB] FAIL to_stop got %b/%b/%h exp 1/11/00", m_cmd_valid, m_cmd_code, m_cmd_data); end
        checks++; if (cmd_ready !== 2'b00) begin errors++; $display("[TB] FAIL to_ready got %b exp 00", cmd_ready); end
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        m_rsp_valid = 1'b1;
        #1;
        checks++; if (rsp_valid !== 2'b00 || m_cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL to_wait got %b/%b exp 00/0", rsp_valid, m_cmd_valid); end
        tick();
        m_rsp_valid = 1'b0;
        req = 2'b00;
        checks++; if (gnt !== 2'b00 || busy !== 1'b0) begin errors++; $display("[TB] FAIL to_release got %b/%b exp 00/0", gnt, busy); end
        checks++; if (timeout_cnt !== 8'd1) begin errors++; $display("[TB] FAIL to_count got %0d exp 1", timeout_cnt); end
        tick();
    endtask

    task automatic test_command_wins();
        req = 2'b01;
        tick();
        do_cmd(0, 2'b00, 8'h90, 8'h00, 1'b0);
        repeat (15) tick();
        cmd_valid[0] = 1'b1;
        cmd_code[1:0] = 2'b01;
        cmd_data[7:0] = 8'h42;
        m_cmd_ready = 1'b1;
        #1;
        checks++; if ({cmd_ready, m_cmd_valid, m_cmd_code, m_cmd_data} !== {2'b01, 1'b1, 2'b01, 8'h42}) begin errors++; $display("[TB] FAIL cw_fwd got %b/%b/%b/%h exp 01/1/01/42", cmd_ready, m_cmd_valid, m_cmd_code, m_cmd_data); end
        tick();
        cmd_valid[0] = 1'b0;
        m_cmd_ready = 1'b0;
        #1;
        checks++; if (m_cmd_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL cw_no_abort got %b/%b exp 0/1", m_cmd_valid, busy); end
        m_rsp_valid = 1'b1;
        tick();
        m_rsp_valid = 1'b0;
        do_cmd(0, 2'b11, 8'h00, 8'h00, 1'b0);
        checks++; if (timeout_cnt !== 8'd1 || gnt !== 2'b01) begin errors++; $display("[TB] FAIL cw_after got %0d/%b exp 1/01", timeout_cnt, gnt); end
        req = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 254; i++) do_abort_cycle();
        checks++; if (timeout_cnt !== 8'd255) begin errors++; $display("[TB] FAIL sat_255 got %0d exp 255", timeout_cnt); end
        for (int i = 0; i < 45; i++) do_abort_cycle();
        checks++; if (timeout_cnt !== 8'd255) begin errors++; $display("[TB] FAIL sat_hold got %0d exp 255", timeout_cnt); end
    endtask

    task automatic test_mid_reset();
        req = 2'b01;
        tick();
        cmd_valid[0] = 1'b1;
        cmd_code[1:0] = 2'b00;
        cmd_data[7:0] = 8'h90;
        m_cmd_ready = 1'b1;
        tick();
        cmd_valid[0] = 1'b0;
        m_cmd_ready = 1'b0;
        req = 2'b00;
        #1;
        checks++; if (busy !== 1'b1 || m_cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL mr_wait got %b/%b exp 1/0", busy, m_cmd_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_rsp_valid = 1'b1;
        m_rsp_data = 8'h5A;
        m_rsp_nack = 1'b1;
        #1;
        checks++; if ({gnt, busy, timeout_cnt} !== 11'd0) begin errors++; $display("[TB] FAIL mr_state got %b/%b/%0d exp 00/0/0", gnt, busy, timeout_cnt); end
        checks++; if ({rsp_valid, rsp_data, rsp_nack, cmd_ready} !== 13'd0) begin errors++; $display("[TB] FAIL mr_rsp got %b/%h/%b/%b exp 0", rsp_valid, rsp_data, rsp_nack, cmd_ready); end
        checks++; if ({m_cmd_valid, m_cmd_code, m_cmd_data} !== 11'd0) begin errors++; $display("[TB] FAIL mr_mcmd got %b/%b/%h exp 0", m_cmd_valid, m_cmd_code, m_cmd_data); end
        tick();
        m_rsp_valid = 1'b0;
        m_rsp_data = 8'h00;
        m_rsp_nack = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        req = 2'b00;
        cmd_valid = 2'b00;
        cmd_code = 4'h0;
        cmd_data = 16'h0000;
        m_cmd_ready = 1'b0;
        m_rsp_valid = 1'b0;
        m_rsp_data = 8'h00;
        m_rsp_nack = 1'b0;
        test_reset();
        test_round_robin();
        test_full_write();
        test_isolation();
        test_protocol_error();
        test_timeout();
        test_command_wins();
        test_saturation();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
